l2_mem_arbiter: RTL and testbench
=================================

Name: l2_mem_arbiter

Overview:
- Shares one 64-bit single-port L2 SRAM macro among NB_MASTERS requesters using a round-robin grant.
- Master side uses the cluster req/gnt/r_valid protocol; memory side drives the L2 macro's active-low CEN/WEN pins with 1-cycle read latency.
- Sits between the SoC-to-L2 interconnect ports and the L2 memory wrapper.
- Optionally zero-fills the whole memory after reset.

Parameters:
- NB_MASTERS, 2, number of requester ports (2..8).
- MEM_ADDR_WIDTH, 15, word (64-bit) address width of the memory.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- req_i  in  NB_MASTERS  per-master request.
- add_i  in  NB_MASTERS*MEM_ADDR_WIDTH  per-master word address; master k occupies slice k.
- wen_i  in  NB_MASTERS  per-master write enable, active-low: 0 = write, 1 = read.
- wdata_i  in  NB_MASTERS*64  per-master write data.
- be_i  in  NB_MASTERS*8  per-master byte enables, active-high.
- gnt_o  out  NB_MASTERS  per-master grant, one-hot or zero.
- r_valid_o  out  NB_MASTERS  per-master response valid, one-hot or zero.
- r_rdata_o  out  64  read data, shared by all masters.
- init_done_o  out  1  high when the arbiter accepts traffic.
- mem_CEN_o  out  1  memory chip enable, active-low.
- mem_WEN_o  out  1  memory write enable, active-low.
- mem_A_o  out  MEM_ADDR_WIDTH  memory address.
- mem_D_o  out  64  memory write data.
- mem_BE_o  out  8  memory byte enables, active-high.
- mem_Q_i  in  64  memory read data, valid one cycle after a read access.

Behaviour:
- Reset values:
  - Registered state: rr_ptr = 0; r_valid_o = 0; resp_idx = 0; state = INIT if the macro is defined, else RUN.
  - Outputs: gnt_o = 0, mem_CEN_o = 1, mem_WEN_o = 1.
- States:
  - INIT: only when the optional feature is compiled in.
  - RUN: normal arbitration.
- RUN arbitration (combinational, same cycle):
  - Winner = the first requesting master found scanning from rr_ptr upward, wrapping modulo NB_MASTERS.
  - gnt_o[winner] = 1. mem_CEN_o = 0. mem_WEN_o, mem_A_o, mem_D_o and mem_BE_o are muxed from the winner.
  - No request: gnt_o = 0, mem_CEN_o = 1, mem_WEN_o = 1; address/data hold don't-care but are driven from master 0.
- Transaction accept: occurs when req_i[k] and gnt_o[k] are both high at a rising edge.
  - Masters hold their request stable until granted.
  - The grant is combinational; masters must not make req depend on gnt.
- Pointer update: on a grant, rr_ptr <= winner+1, wrapping from NB_MASTERS-1 to 0. With no grant, rr_ptr holds.
- Response timing:
  - r_valid_o[winner] is high exactly 1 cycle after the grant, for reads and writes alike (a write acknowledge).
  - resp_idx stores the winner at the grant.
- Read data: r_rdata_o = mem_Q_i, passed combinationally. It is meaningful only while r_valid_o is high for a read. No data register is added.
- Throughput: one access per cycle. Back-to-back grants to the same or different masters are allowed. A response and a new grant in the same cycle is the normal case.
- Starvation bound: a continuously requesting master is granted within NB_MASTERS cycles.
- Asynchronous reset mid-operation:
  - Any pending response is dropped and r_valid_o clears immediately.
  - The memory access already clocked completes silently.
- init_done_o = (state == RUN).
- While not in RUN: gnt_o = 0 and requests are ignored (held).

Optional Feature:
- Macro: L2_ARB_INIT_EN.
- Defined:
  - After reset, state = INIT with an init counter at 0.
  - Each cycle: mem_CEN_o = 0, mem_WEN_o = 0, mem_A_o = counter, mem_D_o = 0, mem_BE_o = 8'hFF. The counter increments.
  - After writing address 2^MEM_ADDR_WIDTH-1, state becomes RUN on the next edge.
  - init_done_o rises 2^MEM_ADDR_WIDTH cycles after reset release. No r_valid is generated for init writes.
- Undefined: no init counter or INIT state. state = RUN out of reset and init_done_o = 1 from reset.

Test Plan:
- Reset, single read: master0 reads address 0x0010 holding 64'hDEADBEEF_CAFEF00D.
  - Required: gnt_o = 01 in the same cycle; mem_CEN_o = 0 and mem_WEN_o = 1.
  - Required next cycle: r_valid_o = 01 and r_rdata_o = 64'hDEADBEEF_CAFEF00D.
- Masked write, then read: master1 writes 64'h11223344_55667788 to 0x7FFF with be = 8'h0F, then reads it back.
  - Required: r_valid_o[1] pulses after each access.
  - Required: the readback shows the low 4 bytes 55667788, with the upper bytes unchanged.
- Contention, NB_MASTERS = 2: both masters request every cycle for 6 cycles.
  - Required: grants alternate 01, 10, 01, 10, 01, 10.
  - Required: r_valid_o follows one cycle later, matching each grant.
- Pointer wrap, NB_MASTERS = 4: a grant goes to master3; then masters 0 and 2 request.
  - Required: the next grant goes to master0 (pointer wrapped to 0), then to master2.
- Reset during traffic: assert RSTN low in the cycle after a read grant.
  - Required: r_valid_o = 0 immediately and gnt_o = 0; after release the first grant goes to master0.
- With L2_ARB_INIT_EN, MEM_ADDR_WIDTH = 4:
  - Required: init_done_o = 0 for 16 cycles, with writes of 0 to addresses 0..15 and requests ignored.
  - Required: then init_done_o = 1, and a read of address 5 returns 0.

Source files
------------

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one 64-bit single-port L2 SRAM among NB_MASTERS requesters.
// Define L2_ARB_INIT_EN to zero-fill the whole memory after reset before accepting traffic.
module l2_mem_arbiter #(
  parameter int unsigned NB_MASTERS     = 2,
  parameter int unsigned MEM_ADDR_WIDTH = 15
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic [NB_MASTERS-1:0]              req_i,
  input  logic [NB_MASTERS*MEM_ADDR_WIDTH-1:0] add_i,
  input  logic [NB_MASTERS-1:0]              wen_i,
  input  logic [NB_MASTERS*64-1:0]           wdata_i,
  input  logic [NB_MASTERS*8-1:0]            be_i,
  output logic [NB_MASTERS-1:0]              gnt_o,
  output logic [NB_MASTERS-1:0]              r_valid_o,
  output logic [63:0]                        r_rdata_o,
  output logic                               init_done_o,
  output logic                               mem_CEN_o,
  output logic                               mem_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0]          mem_A_o,
  output logic [63:0]                        mem_D_o,
  output logic [7:0]                         mem_BE_o,
  input  logic [63:0]                        mem_Q_i
);

  localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam logic [IDX_W:0]   NB_W   = (IDX_W+1)'(NB_MASTERS);
  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(NB_MASTERS - 1);

  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          resp_idx_q, resp_idx_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [IDX_W-1:0]          winner;
  logic                      found;
  logic                      run_en;
  logic                      init_act;
  logic                      grant;
  logic [MEM_ADDR_WIDTH-1:0] init_addr;

`ifdef L2_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign init_done_o = (state_q == ST_RUN);
  assign run_en      = RSTN && (state_q == ST_RUN);
  assign init_act    = RSTN && (state_q == ST_INIT);
  assign init_addr   = init_cnt_q;
`else
  assign init_done_o = 1'b1;
  assign run_en      = RSTN;
  assign init_act    = 1'b0;
  assign init_addr   = '0;
`endif

  // Scan from rr_ptr upward; the candidate index wraps modulo NB_MASTERS,
  // which need not be a power of two.
  always_comb begin
    logic [IDX_W:0] cand;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= NB_W) begin
        cand = cand - NB_W;
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign grant = run_en && found;
  assign gnt_o = grant ? (NB_MASTERS'(1) << winner) : '0;

  always_comb begin
    mem_CEN_o = 1'b1;
    mem_WEN_o = 1'b1;
    mem_A_o   = add_i[MEM_ADDR_WIDTH-1:0];
    mem_D_o   = wdata_i[63:0];
    mem_BE_o  = be_i[7:0];
    for (int unsigned k = 0; k < NB_MASTERS; k++) begin
      if (winner == IDX_W'(k)) begin
        mem_A_o  = add_i[k*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        mem_D_o  = wdata_i[k*64 +: 64];
        mem_BE_o = be_i[k*8 +: 8];
      end
    end
    if (grant) begin
      mem_CEN_o = 1'b0;
      mem_WEN_o = wen_i[winner];
    end
    if (init_act) begin
      mem_CEN_o = 1'b0;
      mem_WEN_o = 1'b0;
      mem_A_o   = init_addr;
      mem_D_o   = '0;
      mem_BE_o  = '1;
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_idx_d   = resp_idx_q;
    resp_valid_d = grant;
    if (grant) begin
      rr_ptr_d   = (winner == LAST_W) ? '0 : winner + 1'b1;
      resp_idx_d = winner;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rr_ptr_q     <= '0;
      resp_idx_q   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_idx_q   <= resp_idx_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // The SRAM output already lags the access by one cycle, so it lines up with r_valid.
  assign r_valid_o = resp_valid_q ? (NB_MASTERS'(1) << resp_idx_q) : '0;
  assign r_rdata_o = mem_Q_i;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench for l2_mem_arbiter with a 4-master instance and a behavioural SRAM.
module tb_l2_mem_arbiter;
`ifdef L2_ARB_INIT_EN
  localparam int AW = 4;
`else
  localparam int AW = 15;
`endif
  localparam int NB = 4;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  logic [NB-1:0]    req;
  logic [AW-1:0]    addr [NB];
  logic [NB-1:0]    wen;
  logic [63:0]      wdata [NB];
  logic [7:0]       be [NB];
  logic [NB*AW-1:0] add_flat;
  logic [NB*64-1:0] wdata_flat;
  logic [NB*8-1:0]  be_flat;

  for (genvar k = 0; k < NB; k++) begin : g_flat
    assign add_flat[k*AW +: AW]   = addr[k];
    assign wdata_flat[k*64 +: 64] = wdata[k];
    assign be_flat[k*8 +: 8]      = be[k];
  end

  logic [NB-1:0] gnt_o, r_valid_o;
  logic [63:0]   r_rdata_o, mem_D, mem_Q;
  logic          init_done_o, mem_CEN, mem_WEN;
  logic [AW-1:0] mem_A;
  logic [7:0]    mem_BE;

  l2_mem_arbiter #(.NB_MASTERS(NB), .MEM_ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .req_i(req), .add_i(add_flat), .wen_i(wen),
    .wdata_i(wdata_flat), .be_i(be_flat), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .init_done_o(init_done_o), .mem_CEN_o(mem_CEN),
    .mem_WEN_o(mem_WEN), .mem_A_o(mem_A), .mem_D_o(mem_D), .mem_BE_o(mem_BE),
    .mem_Q_i(mem_Q)
  );

  logic [63:0] mem [0:(1<<AW)-1];
  bit loaded = 1'b0;
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 64'hA5A5_A5A5_A5A5_A5A5;
`ifndef L2_ARB_INIT_EN
      mem[AW'('h0010)] <= 64'hDEADBEEF_CAFEF00D;
      mem[AW'('h0020)] <= 64'h01234567_89ABCDEF;
      mem[AW'('h0030)] <= 64'hFEDCBA98_76543210;
      mem[AW'('h7FFF)] <= 64'hAAAABBBB_CCCCDDDD;
`endif
      loaded <= 1'b1;
    end else if (!mem_CEN) begin
      if (!mem_WEN) begin
        for (int b = 0; b < 8; b++)
          if (mem_BE[b]) mem[mem_A][b*8 +: 8] <= mem_D[b*8 +: 8];
      end else begin
        mem_Q <= mem[mem_A];
      end
    end
  end

  typedef struct {
    int          idx;
    bit          is_read;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   started = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTN && started) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_e = sbq.pop_front();
        chk("r_valid", 64'(r_valid_o), 64'(1) << mon_e.idx);
        if (mon_e.is_read) chk("r_rdata", r_rdata_o, mon_e.data);
      end else begin
        chk("r_valid_idle", 64'(r_valid_o), 64'd0);
      end
    end
  end

  // Called just after a rising edge; checks the arbitration of the current cycle.
  task automatic step(input logic [NB-1:0] exp_gnt, input logic [63:0] rd_data);
    int   idx;
    exp_t e;
    idx = -1;
    for (int k = 0; k < NB; k++) if (exp_gnt[k]) idx = k;
    @(negedge CLK);
    chk("gnt", 64'(gnt_o), 64'(exp_gnt));
    chk("mem_CEN", 64'(mem_CEN), (idx < 0) ? 64'd1 : 64'd0);
    if (idx >= 0) begin
      chk("mem_WEN", 64'(mem_WEN), 64'(wen[idx]));
      chk("mem_A", 64'(mem_A), 64'(addr[idx]));
      e.idx = idx; e.is_read = wen[idx]; e.data = rd_data; e.due = cyc + 1;
      sbq.push_back(e);
    end else begin
      chk("mem_WEN_idle", 64'(mem_WEN), 64'd1);
    end
    @(posedge CLK);
    #1;
    if (idx >= 0) req[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    wen = '1;
    for (int k = 0; k < NB; k++) begin
      addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end
    req[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_CEN", 64'(mem_CEN), 64'd1);
    chk("rst_WEN", 64'(mem_WEN), 64'd1);
    chk("rst_r_valid", 64'(r_valid_o), 64'd0);
`ifdef L2_ARB_INIT_EN
    chk("rst_init_done", 64'(init_done_o), 64'd0);
    addr[0] = AW'(5);
    RSTN = 1'b1;
    started = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      chk("init_done_low", 64'(init_done_o), 64'd0);
      chk("init_CEN", 64'(mem_CEN), 64'd0);
      chk("init_WEN", 64'(mem_WEN), 64'd0);
      chk("init_A", 64'(mem_A), 64'(i));
      chk("init_D", mem_D, 64'd0);
      chk("init_BE", 64'(mem_BE), 64'hFF);
      chk("init_gnt", 64'(gnt_o), 64'd0);
    end
    @(posedge CLK);
    #1;
    step(4'b0001, 64'd0);
    chk("init_done_high", 64'(init_done_o), 64'd1);
    step(4'b0000, 64'd0);
`else
    chk("rst_init_done", 64'(init_done_o), 64'd1);
    req = '0;
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    started = 1'b1;

    req[0] = 1'b1; wen[0] = 1'b1; addr[0] = AW'('h0010);
    step(4'b0001, 64'hDEADBEEF_CAFEF00D);

    req[1] = 1'b1; wen[1] = 1'b0; addr[1] = AW'('h7FFF);
    wdata[1] = 64'h11223344_55667788; be[1] = 8'h0F;
    step(4'b0010, 64'd0);
    req[1] = 1'b1; wen[1] = 1'b1;
    step(4'b0010, 64'hAAAABBBB_55667788);
    step(4'b0000, 64'd0);

    for (int i = 0; i < 6; i++) begin
      req[0] = 1'b1; req[1] = 1'b1;
      if (i % 2 == 0) step(4'b0001, 64'hDEADBEEF_CAFEF00D);
      else            step(4'b0010, 64'hAAAABBBB_55667788);
    end
    req = '0;

    req[3] = 1'b1; wen[3] = 1'b1; addr[3] = AW'('h0020);
    step(4'b1000, 64'h01234567_89ABCDEF);
    req[0] = 1'b1; req[2] = 1'b1; wen[2] = 1'b1; addr[2] = AW'('h0030);
    step(4'b0001, 64'hDEADBEEF_CAFEF00D);
    step(4'b0100, 64'hFEDCBA98_76543210);

    req[0] = 1'b1;
    step(4'b0001, 64'hDEADBEEF_CAFEF00D);
    req[0] = 1'b1; req[1] = 1'b1;
    RSTN = 1'b0;
    sbq.delete();
    #1;
    chk("rst_mid_r_valid", 64'(r_valid_o), 64'd0);
    chk("rst_mid_gnt", 64'(gnt_o), 64'd0);
    chk("rst_mid_CEN", 64'(mem_CEN), 64'd1);
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    step(4'b0001, 64'hDEADBEEF_CAFEF00D);
    step(4'b0010, 64'hAAAABBBB_55667788);
    step(4'b0000, 64'd0);
`endif
    @(negedge CLK);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
